// File: rtl/mux_pkg.sv
// Shared definitions for the lane interleaver and its arbiters.
// Mode encodings and the lane-index width helper.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_SKIP  = 1'b1;

  function automatic int lane_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_rr_pick.sv
// Circular first-set finder: the lowest set req bit at or after
// start, wrapping past the last lane back to lane 0.
module lane_rr_pick
  import mux_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = lane_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    start,
  output logic                 found,
  output logic [LANE_W-1:0]    idx
);

  int k;

  // Walk offsets downward so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    k     = 0;
    for (int o = NUM_LANES - 1; o >= 0; o--) begin
      k = int'(start) + o;
      if (k >= NUM_LANES) begin
        k = k - NUM_LANES;
      end
      if (req[k]) begin
        found = 1'b1;
        idx   = LANE_W'(k);
      end
    end
  end

endmodule

// File: rtl/lane_interleaver.sv
// N-lane to one-stream word interleaver with one holding register
// per lane and a round-robin slot pointer, fixed or skip slotting.
module lane_interleaver
  import mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_LANES  = 4,
  localparam int LANE_W     = lane_w(NUM_LANES)
) (
  input  logic                            clk_4f,
  input  logic                            reset,
  input  logic                            mode_skip,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_LANES-1:0]            in_valid,
  output logic [NUM_LANES-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic [LANE_W-1:0]               out_lane,
  input  logic                            out_ready
);

  logic [NUM_LANES-1:0]  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] hold_data_q [NUM_LANES];
  logic [DATA_WIDTH-1:0] hold_data_d [NUM_LANES];
  logic [LANE_W-1:0]     ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic [LANE_W-1:0]     out_lane_q, out_lane_d;

  logic              adv;
  logic              drain;
  logic              sel_valid;
  logic [LANE_W-1:0] sel;
  logic              pick_found;
  logic [LANE_W-1:0] pick_idx;

  function automatic logic [LANE_W-1:0] wrap_inc(
    input logic [LANE_W-1:0] x
  );
    return (x == LANE_W'(NUM_LANES - 1)) ? '0 : x + 1'b1;
  endfunction

  lane_rr_pick #(
    .NUM_LANES (NUM_LANES),
    .LANE_W    (LANE_W)
  ) u_pick (
    .req   (hold_full_q),
    .start (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    adv = !out_valid_q || out_ready;
    if (mode_skip == MODE_SKIP) begin
      sel       = pick_idx;
      sel_valid = pick_found;
    end else begin
      sel       = ptr_q;
      sel_valid = hold_full_q[ptr_q];
    end
    drain = adv && sel_valid;
  end

  // A lane being drained this cycle may accept its next word at once.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      in_ready[i] = !reset &&
        (!hold_full_q[i] || (drain && sel == LANE_W'(i)));
    end
  end

  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (drain) begin
      hold_full_d[sel] = 1'b0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        hold_full_d[i] = 1'b1;
        hold_data_d[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    if (adv) begin
      if (sel_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = hold_data_q[sel];
        out_lane_d  = sel;
        ptr_d       = wrap_inc(sel);
      end else begin
        out_valid_d = 1'b0;
        // An empty fixed slot is still spent; skip mode just waits.
        if (mode_skip == MODE_FIXED) begin
          out_lane_d = ptr_q;
          ptr_d      = wrap_inc(ptr_q);
        end
      end
    end
  end

  always_ff @(posedge clk_4f) begin
    if (reset) begin
      hold_full_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        hold_data_q[i] <= '0;
      end
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      for (int i = 0; i < NUM_LANES; i++) begin
        hold_data_q[i] <= hold_data_d[i];
      end
      ptr_q       <= ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_lane  = out_lane_q;

endmodule

// File: doc/lane_interleaver.md
Name: lane_interleaver

Overview:
- Parametrised N-lane to 1-stream byte interleaver. It is the single-clock successor of the two-level 4:1 mux tree.
- Each lane delivers words through a valid/ready handshake into a one-entry holding register.
- A round-robin slot pointer drains the holding registers onto one registered output stream with backpressure.
- Two modes: fixed slotting (lane order preserved, idle slots emitted) and skip (work-conserving).

Parameters:
- DATA_WIDTH, 8: bits per lane word.
- NUM_LANES, 4: number of input lanes, >= 2. Not required to be a power of two.
- LANE_W, $clog2(NUM_LANES): localparam, lane index width.

Ports:
- clk_4f  in  1  single clock, output word rate.
- reset  in  1  synchronous, active-high.
- mode_skip  in  1  0 = fixed slotting, 1 = skip empty lanes.
- in_data  in  NUM_LANES*DATA_WIDTH  lane i word occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  in  NUM_LANES  per-lane word valid.
- in_ready  out  NUM_LANES  per-lane accept.
- out_data  out  DATA_WIDTH  interleaved word.
- out_valid  out  1  out_data holds a real word.
- out_lane  out  LANE_W  source lane of the current slot.
- out_ready  in  1  downstream accept.

Behaviour:
- State:
  - hold_data[i] and hold_full[i] per lane.
  - Output registers: out_data, out_valid, out_lane.
  - Slot pointer ptr, LANE_W bits.
- Reset, sampled on the clock edge: hold_full = 0, ptr = 0, out_valid = 0, out_data = 0, out_lane = 0. in_ready = 0 in every cycle reset is high.
- Reset mid-operation: all buffered words are discarded with no output.
- adv = !out_valid || out_ready. The output registers and ptr update only when adv = 1; otherwise they are held.
- Holding register rules:
  - in_ready[i] = !reset && (!hold_full[i] || (adv && sel_valid && sel == i)).
  - A lane is allowed to be drained and refilled in the same cycle.
  - This is a combinational path from out_ready to in_ready.
- Fixed mode (mode_skip = 0), on adv:
  - sel = ptr. out_lane <= ptr.
  - If hold_full[ptr]: out_data <= hold_data[ptr], out_valid <= 1, hold_full[ptr] cleared unless refilled.
  - Otherwise: out_valid <= 0 (idle slot) and out_data is held.
  - ptr <= (ptr == NUM_LANES-1) ? 0 : ptr+1.
- Skip mode (mode_skip = 1), on adv:
  - sel = first lane k with hold_full[k], searched circularly starting at ptr.
  - If found: load as in fixed mode, out_lane <= k, ptr <= k+1 with wrap.
  - If none found: out_valid <= 0, out_lane and ptr unchanged.
- mode_skip is sampled every cycle and takes effect at the next adv. ptr is retained across mode changes.
- Latency:
  - A word accepted in cycle t appears on out_valid/out_data in cycle t+2 at the earliest.
  - In fixed mode, add up to NUM_LANES-1 cycles of slot wait.
- Throughput: one word per cycle while out_ready = 1.
- Ordering: no word is lost or duplicated. Per-lane order is preserved.
- While out_valid = 1 and out_ready = 0, out_data and out_lane are stable.
- Wrap: ptr never takes a value >= NUM_LANES.

Decomposition:
- Shared package mux_pkg:
  - MODE_FIXED = 1'b0, MODE_SKIP = 1'b1.
  - Lane-index width function.
- One sub-module, lane_rr_pick: combinational circular first-set finder.
  - Inputs: req[NUM_LANES], start[LANE_W].
  - Outputs: found, idx[LANE_W].
  - Reusable by future arbiters.

Test Plan:
1. Reset: assert reset 2 cycles with in_valid = 4'hF, in_data lanes 0xA0..0xA3 -> in_ready = 0, out_valid = 0, out_data = 0x00, out_lane = 0 throughout. First accept occurs the cycle after release.
2. Fixed mode, all lanes streaming, out_ready = 1: lanes present 0xA0..0xA3 continuously -> first out_valid 2 cycles after first accept, then A0/0, A1/1, A2/2, A3/3 repeating every cycle.
3. Fixed mode, lane 2 silent: lanes 0, 1, 3 send 0x10, 0x11, 0x13 -> per cycle out_valid = 1,1,0,1 with out_lane = 0,1,2,3 and data 10, 11, (idle), 13.
4. Skip mode, only lanes 1 and 3 active with 0x21 and 0x23 -> out alternates 21/lane1, 23/lane3 every cycle, with no idle cycles.
5. Backpressure: out_ready = 0 for 3 cycles mid-stream:
   - out_data, out_lane and ptr remain stable.
   - in_ready = 0 for full lanes.
   - On release, output resumes at the next lane with every word emitted exactly once.
6. Reset mid-stream plus NUM_LANES = 5:
   - With all holds full, assert reset 1 cycle -> everything clears.
   - After release, out_lane sequence is 0,1,2,3,4,0, confirming wrap at a non-power-of-two lane count.
